// File: rtl/ysyx_040750_csr_pkg.sv
// Shared CSR addresses, arbiter state encoding and holdoff counter width
// for the machine-mode interrupt path.
package ysyx_040750_csr_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;

    // Holdoff is limited to 1..15, so four bits always suffice.
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_BUSY = 2'd2,
        ST_HOLD = 2'd3
    } arb_state_e;

endpackage

// File: rtl/ysyx_040750_intr_kill.sv
// Speculative interrupt suppression from the in-flight pipeline stages:
// any trap or disabling mstatus/mie write downstream masks requests now.
module ysyx_040750_intr_kill
    import ysyx_040750_csr_pkg::*;
#(
    parameter int NSRC   = 3,
    parameter int NSTAGE = 3
) (
    input  logic [NSTAGE-1:0]          stage_intr,
    input  logic [NSTAGE-1:0]          stage_csr_wen,
    input  logic [12*NSTAGE-1:0]       stage_csr_addr,
    input  logic [(NSRC+1)*NSTAGE-1:0] stage_csr_data,
    output logic [NSRC-1:0]            kill,
    output logic                       kill_all
);

    logic [11:0]   addr_k;
    logic [NSRC:0] data_k;
    logic          wr_mie_k;
    logic          wr_mst_k;

    // Only clearing writes matter; a setting write must wait for commit.
    always_comb begin
        kill     = '0;
        kill_all = |stage_intr;
        addr_k   = '0;
        data_k   = '0;
        wr_mie_k = 1'b0;
        wr_mst_k = 1'b0;
        for (int k = 0; k < NSTAGE; k++) begin
            addr_k   = stage_csr_addr[12*k +: 12];
            data_k   = stage_csr_data[(NSRC+1)*k +: (NSRC+1)];
            wr_mie_k = stage_csr_wen[k] && (addr_k == CSR_MIE);
            wr_mst_k = stage_csr_wen[k] && (addr_k == CSR_MSTATUS);
            if (wr_mst_k && !data_k[0]) begin
                kill_all = 1'b1;
            end
            if (wr_mie_k) begin
                kill = kill | ~data_k[NSRC:1];
            end
        end
    end

endmodule

// File: rtl/ysyx_040750_intr_arb.sv
// Machine-mode interrupt arbiter: qualifies raw lines, picks the lowest
// index eligible source and hands it to ID under a req/take handshake.
//
// state | meaning
// IDLE  | no request outstanding, arbitrating every cycle
// REQ   | id_q latched, request shown while that source stays eligible
// BUSY  | ID took the interrupt, handler running until mret
// HOLD  | post-mret holdoff, cnt counts down to zero
module ysyx_040750_intr_arb
    import ysyx_040750_csr_pkg::*;
#(
    parameter int NSRC    = 3,
    parameter int NSTAGE  = 3,
    parameter int HOLDOFF = 3,
    parameter int IDW     = (NSRC > 1) ? $clog2(NSRC) : 1
) (
    input  logic                       I_sys_clk,
    input  logic                       I_rst,
    input  logic [NSRC-1:0]            I_irq,
    input  logic [NSRC-1:0]            I_mie,
    input  logic                       I_mstatus_mie,
    input  logic [NSTAGE-1:0]          I_stage_intr,
    input  logic [NSTAGE-1:0]          I_stage_csr_wen,
    input  logic [12*NSTAGE-1:0]       I_stage_csr_addr,
    input  logic [(NSRC+1)*NSTAGE-1:0] I_stage_csr_data,
    input  logic                       I_take,
    input  logic                       I_mret,
    output logic                       O_intr_req,
    output logic [IDW-1:0]             O_intr_id,
    output logic                       O_busy
);

    arb_state_e        state_q;
    arb_state_e        state_d;
    logic [IDW-1:0]    id_q;
    logic [IDW-1:0]    id_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;

    logic [NSRC-1:0]   kill;
    logic              kill_all;
    logic [NSRC-1:0]   elig;
    logic [IDW-1:0]    enc_id;
    logic              any_elig;
    logic              cur_elig;

    ysyx_040750_intr_kill #(
        .NSRC   (NSRC),
        .NSTAGE (NSTAGE)
    ) u_kill (
        .stage_intr     (I_stage_intr),
        .stage_csr_wen  (I_stage_csr_wen),
        .stage_csr_addr (I_stage_csr_addr),
        .stage_csr_data (I_stage_csr_data),
        .kill           (kill),
        .kill_all       (kill_all)
    );

    assign elig     = I_irq & I_mie & {NSRC{I_mstatus_mie}} & ~kill & {NSRC{~kill_all}};
    assign any_elig = |elig;
    assign cur_elig = elig[id_q];

    // Scan from the top so the lowest eligible index is the last one written.
    always_comb begin
        enc_id = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (elig[i]) begin
                enc_id = IDW'(i);
            end
        end
    end

    always_ff @(posedge I_sys_clk or posedge I_rst) begin
        if (I_rst) begin
            state_q <= ST_IDLE;
            id_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        id_d       = id_q;
        cnt_d      = cnt_q;
        O_intr_req = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (any_elig) begin
                    id_d    = enc_id;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                O_intr_req = cur_elig;
                // A take only counts while the request is actually visible.
                if (I_take && cur_elig) begin
                    state_d = ST_BUSY;
                end else if (!cur_elig) begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (I_mret) begin
                    cnt_d   = CNT_W'(HOLDOFF - 1);
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign O_intr_id = id_q;
    assign O_busy    = (state_q == ST_BUSY) || (state_q == ST_HOLD);

endmodule

// File: tb/tb_ysyx_040750_intr_arb.sv
// Directed bench for the interrupt arbiter: handshake, priority, withdrawal,
// speculative kills, mret holdoff and asynchronous reset.
module tb_ysyx_040750_intr_arb;

    localparam int NSRC    = 3;
    localparam int NSTAGE  = 3;
    localparam int HOLDOFF = 3;
    localparam int IDW     = 2;

    logic                       clk;
    logic                       rst;
    logic [NSRC-1:0]            irq;
    logic [NSRC-1:0]            mie;
    logic                       mstatus_mie;
    logic [NSTAGE-1:0]          stage_intr;
    logic [NSTAGE-1:0]          stage_csr_wen;
    logic [12*NSTAGE-1:0]       stage_csr_addr;
    logic [(NSRC+1)*NSTAGE-1:0] stage_csr_data;
    logic                       take;
    logic                       mret;
    logic                       intr_req;
    logic [IDW-1:0]             intr_id;
    logic                       busy;

    int checks = 0;
    int errors = 0;

    ysyx_040750_intr_arb #(
        .NSRC    (NSRC),
        .NSTAGE  (NSTAGE),
        .HOLDOFF (HOLDOFF),
        .IDW     (IDW)
    ) dut (
        .I_sys_clk        (clk),
        .I_rst            (rst),
        .I_irq            (irq),
        .I_mie            (mie),
        .I_mstatus_mie    (mstatus_mie),
        .I_stage_intr     (stage_intr),
        .I_stage_csr_wen  (stage_csr_wen),
        .I_stage_csr_addr (stage_csr_addr),
        .I_stage_csr_data (stage_csr_data),
        .I_take           (take),
        .I_mret           (mret),
        .O_intr_req       (intr_req),
        .O_intr_id        (intr_id),
        .O_busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic outs(input string tag, input logic r, input logic [IDW-1:0] id, input logic b);
        chk({tag, ".req"},  32'(intr_req), 32'(r));
        chk({tag, ".id"},   32'(intr_id),  32'(id));
        chk({tag, ".busy"}, 32'(busy),     32'(b));
    endtask

    initial begin
        rst            = 1'b1;
        irq            = '0;
        mie            = 3'b111;
        mstatus_mie    = 1'b1;
        stage_intr     = '0;
        stage_csr_wen  = '0;
        stage_csr_addr = '0;
        stage_csr_data = '0;
        take           = 1'b0;
        mret           = 1'b0;

        step();
        step();
        outs("reset", 1'b0, 2'd0, 1'b0);
        rst = 1'b0;

        // single source, one cycle of arbitration latency, then take
        irq = 3'b010;
        settle();
        chk("a.idle_req", 32'(intr_req), 32'd0);
        step();
        outs("a.req", 1'b1, 2'd1, 1'b0);
        take = 1'b1;
        step();
        take = 1'b0;
        outs("a.taken", 1'b0, 2'd1, 1'b1);

        // mret with irq still eligible: request returns HOLDOFF+1 edges later
        mret = 1'b1;
        step();
        mret = 1'b0;
        outs("e.hold0", 1'b0, 2'd1, 1'b1);
        step();
        chk("e.hold1.req", 32'(intr_req), 32'd0);
        step();
        outs("e.hold2", 1'b0, 2'd1, 1'b1);
        step();
        outs("e.idle", 1'b0, 2'd1, 1'b0);
        step();
        outs("e.rereq", 1'b1, 2'd1, 1'b0);
        irq = 3'b000;
        step();

        // priority and withdrawal
        irq = 3'b110;
        step();
        outs("b.prio", 1'b1, 2'd1, 1'b0);
        irq = 3'b100;
        settle();
        chk("b.drop.req", 32'(intr_req), 32'd0);
        step();
        outs("b.withdrawn", 1'b0, 2'd1, 1'b0);
        step();
        outs("b.next", 1'b1, 2'd2, 1'b0);
        irq = 3'b000;
        step();

        // EX-stage mstatus.MIE clear kills the request and the take with it
        irq = 3'b001;
        step();
        outs("c.req", 1'b1, 2'd0, 1'b0);
        stage_csr_wen  = 3'b001;
        stage_csr_addr = 36'h000000300;
        stage_csr_data = 12'h00E;
        take           = 1'b1;
        settle();
        chk("c.kill.req", 32'(intr_req), 32'd0);
        step();
        take           = 1'b0;
        stage_csr_wen  = '0;
        stage_csr_addr = '0;
        stage_csr_data = '0;
        outs("c.not_busy", 1'b0, 2'd0, 1'b0);
        step();
        chk("c.rereq", 32'(intr_req), 32'd1);
        stage_intr = 3'b100;
        settle();
        chk("c.trap.req", 32'(intr_req), 32'd0);
        step();
        stage_intr = '0;
        irq        = 3'b000;
        step();

        // MEM-stage mie write clearing source 1
        stage_csr_wen  = 3'b010;
        stage_csr_addr = 36'h000304000;
        stage_csr_data = 12'h0B0;
        irq            = 3'b010;
        step();
        outs("d.masked", 1'b0, 2'd0, 1'b0);
        step();
        chk("d.masked2.req", 32'(intr_req), 32'd0);
        irq = 3'b011;
        step();
        outs("d.src0", 1'b1, 2'd0, 1'b0);
        take = 1'b1;
        step();
        take = 1'b0;
        chk("d.busy", 32'(busy), 32'd1);

        // async reset in BUSY, then a fresh request after release
        stage_csr_wen  = '0;
        stage_csr_addr = '0;
        stage_csr_data = '0;
        irq            = 3'b010;
        #2;
        rst = 1'b1;
        #1;
        outs("r.async", 1'b0, 2'd0, 1'b0);
        step();
        rst = 1'b0;
        settle();
        chk("r.released.req", 32'(intr_req), 32'd0);
        step();
        outs("r.rereq", 1'b1, 2'd1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ysyx_040750_intr_arb.md
# ysyx_040750_intr_arb

Parametrised machine-mode interrupt arbiter between the CSR file and the ID stage of the 5-stage pipeline. Takes NSRC level-sensitive interrupt lines, qualifies each by its committed mie bit and mstatus.MIE, suppresses speculatively on any in-flight disabling CSR write or in-flight trap in the NSTAGE downstream stages, and presents one fixed-priority request to ID under a req/take handshake. Tracks handler entry/exit so no second request is raised until mret plus a programmable holdoff.

## Interface
- NSRC, 3: number of interrupt sources; index 0 = highest priority (integrator orders lines MEI, MSI, MTI).
- NSTAGE, 3: in-flight stages checked (EX, MEM, WB; stage 0 = EX).
- HOLDOFF, 3: cycles after mret before arbitration resumes; legal 1..15.
- IDW, $clog2(NSRC) (min 1): width of O_intr_id.

- I_sys_clk  in  1  clock, rising edge.
- I_rst  in  1  reset, asynchronous, active-high.
- I_irq  in  NSRC  raw interrupt levels.
- I_mie  in  NSRC  committed mie enable bits, same order as I_irq.
- I_mstatus_mie  in  1  committed mstatus.MIE.
- I_stage_intr  in  NSTAGE  trap/interrupt in flight in stage k.
- I_stage_csr_wen  in  NSTAGE  CSR write in flight in stage k.
- I_stage_csr_addr  in  12*NSTAGE  CSR address, stage k at [12k+11:12k].
- I_stage_csr_data  in  (NSRC+1)*NSTAGE  write data slice, stage k = {mie bits[NSRC-1:0], mstatus_mie}.
- I_take  in  1  ID commits to the presented interrupt.
- I_mret  in  1  mret retired in WB.
- O_intr_req  out  1  interrupt request to ID.
- O_intr_id  out  IDW  source index of current request.
- O_busy  out  1  handler active (BUSY or HOLD).

## Operation
- Per stage k: wr_mie_k = wen_k & addr_k==CSR_MIE; wr_mst_k = wen_k & addr_k==CSR_MSTATUS.
- kill_all = |I_stage_intr | any(wr_mst_k & ~data_k[0]).
- kill[i] = any(wr_mie_k & ~data_k[i+1]).
- elig[i] = I_irq[i] & I_mie[i] & I_mstatus_mie & ~kill[i] & ~kill_all. In-flight enabling writes never enable early.
- FSM states: IDLE, REQ, BUSY, HOLD.
- IDLE: if |elig, latch id_q = lowest-index eligible source, go REQ.
- REQ: O_intr_req = elig[id_q] (combinational). If I_take & O_intr_req, go BUSY. Else if ~elig[id_q], go IDLE (withdraw, re-arbitrate next cycle). id_q stable throughout REQ.
- BUSY: O_intr_req=0; on I_mret load cnt=HOLDOFF-1, go HOLD.
- HOLD: decrement cnt; at cnt==0 go IDLE.
- I_take ignored unless O_intr_req=1 same cycle. I_mret ignored outside BUSY. I_take and withdrawal same cycle: take wins only if O_intr_req=1.

## Timing
- Reset: state IDLE, id_q=0, cnt=0; O_intr_req=0, O_intr_id=0, O_busy=0.
- Eligible in cycle n (IDLE) -> O_intr_req=1 in cycle n+1 if still eligible.
- Disabling CSR write or trap entering any checked stage drops O_intr_req in the same cycle (zero latency).
- I_take at edge n -> O_busy=1, O_intr_req=0 from n+1.
- I_mret at edge n -> HOLD for HOLDOFF cycles -> IDLE; earliest next request HOLDOFF+1 cycles after the mret edge.
- Reset mid-handler returns to IDLE immediately; no pending state survives.

## Structure
- Shared package ysyx_040750_csr_pkg: CSR_MSTATUS=12'h300, CSR_MIE=12'h304, FSM state enum (2-bit).
- One sub-module: ysyx_040750_intr_kill (combinational kill/kill_all from stage vectors, parametrised NSTAGE, NSRC); arbiter FSM and priority encoder stay in top.

## Test plan
- I_irq=3'b010, I_mie=3'b111, mstatus_mie=1 -> req=1, id=1 next cycle; I_take -> busy=1, req=0.
- I_irq=3'b110, all enabled -> id=1 (index 1 beats 2); irq[1] drops in REQ -> req=0 same cycle, IDLE, next request id=2.
- In REQ, EX stage csr_wen, addr 12'h300, data[0]=0 -> req=0 same cycle; I_take that cycle ignored, state stays non-BUSY.
- MEM stage writes 12'h304 with bit for source 1 cleared while irq[1] pending -> no request; source 0 pending concurrently -> id=0 requested.
- HOLDOFF=3: mret at cycle 10 with irq still eligible -> req reasserts cycle 14, not earlier.
- I_rst pulsed asynchronously in BUSY -> outputs 0 immediately; after release, pending irq re-requests.
